spi_mem_slave: RTL

- SPI-side memory target that sits directly downstream of the team's SPI master.
- Consumes the master's o_cs / o_mosi frame and produces the master's i_ready, i_op_done and i_miso inputs.
- Holds a small register-file memory: 32 x 8 by default.
- Decodes write frames (op, addr, data) and read frames (op, addr), then answers reads with an 8-bit LSB-first response.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_mem_array.sv | 43 ++++
 rtl/spi_mem_slave.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master / memory-slave pair.
// Holds frame opcodes, default geometry and the slave state encoding.
package spi_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 8;
  localparam int MEM_DEPTH = 32;

  localparam logic OP_WR = 1'b1;
  localparam logic OP_RD = 1'b0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SKIP    = 3'd1,
    RX_OP   = 3'd2,
    RX_ADDR = 3'd3,
    RX_DATA = 3'd4,
    END     = 3'd5,
    READY   = 3'd6,
    TX      = 3'd7
  } spi_state_e;

endpackage

// File: rtl/spi_mem_array.sv
// DEPTH x DATA_W register-file storage.
// Out-of-range accesses are dropped on write and read back as zero.
module spi_mem_array #(
  parameter int DATA_W = spi_pkg::DATA_W,
  parameter int ADDR_W = spi_pkg::ADDR_W,
  parameter int DEPTH  = spi_pkg::MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int             IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  // The full address is compared so aliased high addresses never reach a word.
  assign in_range = ({1'b0, addr} < DEPTH_LIM);
  assign idx      = addr[IDX_W-1:0];

  // NOTE: this storage is flops, not a RAM macro, so a synchronous clear is
  // legal here; a real SRAM would need a sequenced clear instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && in_range) begin
      mem[idx] <= wdata;
    end
  end

  // NOTE: default assignment first so every path drives rdata and no latch forms.
  always_comb begin
    rdata = '0;
    if (in_range) rdata = mem[idx];
  end

endmodule

// File: rtl/spi_mem_slave.sv
// SPI-side memory target: decodes write/read frames from the SPI master
// and answers reads with an LSB-first response on o_miso.
module spi_mem_slave
  import spi_pkg::*;
#(
  parameter int DATA_W = spi_pkg::DATA_W,
  parameter int ADDR_W = spi_pkg::ADDR_W,
  parameter int DEPTH  = spi_pkg::MEM_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic i_cs,
  input  logic i_mosi,
  output logic o_ready,
  output logic o_op_done,
  output logic o_miso
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  spi_state_e        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic              op;
  logic [ADDR_W-1:0] addr_sr;
  logic [DATA_W-1:0] data_sr;
  logic [DATA_W-1:0] tx_reg;
  logic [DATA_W-1:0] rd_data;
  logic              mem_we;

  // Commit happens on the same edge that sees chip-select released.
  assign mem_we = (state == END) && i_cs && (op == OP_WR);

  spi_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .addr  (addr_sr),
    .wdata (data_sr),
    .rdata (rd_data)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      op        <= 1'b0;
      addr_sr   <= '0;
      data_sr   <= '0;
      tx_reg    <= '0;
      o_ready   <= 1'b0;
      o_op_done <= 1'b0;
      o_miso    <= 1'b0;
    end else begin
      o_ready   <= 1'b0;
      o_op_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_cs) begin
            bit_cnt <= '0;
            state   <= SKIP;
          end
        end
        SKIP: state <= i_cs ? IDLE : RX_OP;
        RX_OP: begin
          if (i_cs) begin
            state <= IDLE;
          end else begin
            op      <= i_mosi;
            bit_cnt <= '0;
            state   <= RX_ADDR;
          end
        end
        RX_ADDR: begin
          if (i_cs) begin
            state <= IDLE;
          end else begin
            addr_sr <= {i_mosi, addr_sr[ADDR_W-1:1]};
            if (bit_cnt == ADDR_LAST) begin
              bit_cnt <= '0;
              state   <= (op == OP_WR) ? RX_DATA : END;
            end else begin
              bit_cnt <= bit_cnt + CNT_ONE;
            end
          end
        end
        RX_DATA: begin
          if (i_cs) begin
            state <= IDLE;
          end else begin
            data_sr <= {i_mosi, data_sr[DATA_W-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= END;
            end else begin
              bit_cnt <= bit_cnt + CNT_ONE;
            end
          end
        end
        END: begin
          if (i_cs) begin
            if (op == OP_WR) begin
              o_op_done <= 1'b1;
              state     <= IDLE;
            end else begin
              tx_reg  <= rd_data;
              o_ready <= 1'b1;
              state   <= READY;
            end
          end
        end
        READY: begin
          o_miso  <= tx_reg[0];
          tx_reg  <= tx_reg >> 1;
          bit_cnt <= '0;
          state   <= TX;
        end
        TX: begin
          // bit_cnt counts bits already driven after bit 0; chip-select is ignored.
          if (bit_cnt == DATA_LAST) begin
            o_miso  <= 1'b0;
            bit_cnt <= '0;
            state   <= IDLE;
          end else begin
            o_miso  <= tx_reg[0];
            tx_reg  <= tx_reg >> 1;
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
